// File: rtl/crc_defs.sv
// rtl/crc_defs.sv - shared CRC constants, FSM encodings and bit-reverse helper
package crc_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

  localparam int unsigned CRC_MAX_W = 64;

  // Reverses the low w bits of v; result is right-aligned so callers can truncate.
  function automatic logic [CRC_MAX_W-1:0] bit_reverse(input logic [CRC_MAX_W-1:0] v,
                                                       input int unsigned w);
    logic [CRC_MAX_W-1:0] r;
    r = {<<{v}};
    return r >> (CRC_MAX_W - w);
  endfunction

endpackage

// File: rtl/crc_step.sv
// rtl/crc_step.sv - combinational next-CRC for one data word, bit-serial unrolled
module crc_step #(
  parameter int unsigned      DW    = 8,
  parameter int unsigned      CRC_W = 32,
  parameter logic [CRC_W-1:0] POLY  = 32'h04C11DB7,
  parameter bit               REFIN = 1'b1
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic [DW-1:0]    data_i,
  output logic [CRC_W-1:0] crc_o
);

  always_comb begin : step
    logic [CRC_W-1:0] c;
    logic             d;
    c = crc_i;
    d = 1'b0;
    for (int i = 0; i < int'(DW); i++) begin
      d = REFIN ? data_i[i] : data_i[int'(DW) - 1 - i];
      c = {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ d) ? POLY : '0);
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc_fifo_drain.sv
// rtl/crc_fifo_drain.sv - FIFO consumer folding popped words into a framed CRC result
module crc_fifo_drain
  import crc_defs::*;
#(
  parameter int unsigned      DW     = 8,
  parameter int unsigned      CRC_W  = 32,
  parameter logic [CRC_W-1:0] POLY   = CRC32_POLY,
  parameter logic [CRC_W-1:0] INIT   = CRC32_INIT,
  parameter logic [CRC_W-1:0] XOROUT = CRC32_XOROUT,
  parameter bit               REFIN  = 1'b1,
  parameter bit               REFOUT = 1'b1,
  parameter int unsigned      LEN_W  = 16
) (
  input  logic             i_par_fifo_clk,
  input  logic             i_par_fifo_reset_b,
  input  logic             i_clr,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_fifo_dempty,
  input  logic [DW-1:0]    i_fifo_drdata,
  output logic             o_fifo_dpop,
  output logic             o_busy,
  output logic [CRC_W-1:0] o_crc,
  output logic             o_crc_valid,
  input  logic             i_crc_ready
);

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] crc_out_q;
  logic [CRC_W-1:0] step_w, refl_w, final_w;
  logic             pop_w;

  assign pop_w = (state_q == ST_RUN) && !i_fifo_dempty && !i_clr;

  crc_step #(
    .DW    (DW),
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .REFIN (REFIN)
  ) u_step (
    .crc_i  (crc_q),
    .data_i (i_fifo_drdata),
    .crc_o  (step_w)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    crc_d       = crc_q;
    if (i_clr) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      crc_d       = INIT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            crc_d = INIT;
            if (i_len != '0) begin
              remaining_d = i_len;
              state_d     = ST_RUN;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (pop_w) begin
            crc_d       = step_w;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == LEN_W'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_crc_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Result is finalised from the next-state CRC so it is ready the cycle DONE is entered.
  assign refl_w  = REFOUT ? CRC_W'(bit_reverse(CRC_MAX_W'(crc_d), CRC_W)) : crc_d;
  assign final_w = refl_w ^ XOROUT;

  always_ff @(posedge i_par_fifo_clk or negedge i_par_fifo_reset_b) begin
    if (!i_par_fifo_reset_b) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      crc_q       <= INIT;
      crc_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      crc_q       <= crc_d;
      if (state_d == ST_DONE && state_q != ST_DONE) crc_out_q <= final_w;
    end
  end

  assign o_fifo_dpop = pop_w;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_crc_valid = (state_q == ST_DONE);
  assign o_crc       = crc_out_q;

endmodule

// File: tb/tb_crc_fifo_drain.sv
// tb/tb_crc_fifo_drain.sv - self-checking bench for crc_fifo_drain against a reflected CRC-32 model
module tb_crc_fifo_drain;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        i_clr = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_len = '0;
  logic        i_fifo_dempty = 1'b1;
  logic [7:0]  i_fifo_drdata = '0;
  logic        o_fifo_dpop;
  logic        o_busy;
  logic [31:0] o_crc;
  logic        o_crc_valid;
  logic        i_crc_ready = 1'b1;

  crc_fifo_drain dut (
    .i_par_fifo_clk     (clk),
    .i_par_fifo_reset_b (rstn),
    .i_clr              (i_clr),
    .i_start            (i_start),
    .i_len              (i_len),
    .i_fifo_dempty      (i_fifo_dempty),
    .i_fifo_drdata      (i_fifo_drdata),
    .o_fifo_dpop        (o_fifo_dpop),
    .o_busy             (o_busy),
    .o_crc              (o_crc),
    .o_crc_valid        (o_crc_valid),
    .i_crc_ready        (i_crc_ready)
  );

  always #5 clk = ~clk;

  int           vectors = 0;
  int           miscompares = 0;
  byte unsigned fq[$];
  byte unsigned src[$];
  int           push_every = 0;
  int           cyc_ctr = 0;
  bit           popped;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reflected CRC-32 (shift-right form), independent of the normal-form datapath.
  function automatic logic [31:0] ref_crc(input byte unsigned d[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      c = c ^ {24'h0, d[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // One clock: called at a negedge, returns at the next negedge.
  task automatic cycle();
    if (push_every > 0 && src.size() > 0 && (cyc_ctr % push_every) == 0)
      fq.push_back(src.pop_front());
    cyc_ctr++;
    i_fifo_dempty = (fq.size() == 0);
    i_fifo_drdata = (fq.size() > 0) ? fq[0] : 8'h00;
    #1;
    popped = o_fifo_dpop;
    chk("pop_when_empty", {63'b0, o_fifo_dpop & i_fifo_dempty}, 64'd0);
    @(posedge clk);
    #1;
    if (popped && fq.size() > 0) void'(fq.pop_front());
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, output int cycles, output int pops, output bit last_pop);
    cycles = 0; pops = 0; last_pop = 1'b0;
    while (o_crc_valid !== 1'b1 && cycles < 400) begin
      cycle();
      cycles++;
      if (popped) pops++;
      last_pop = popped;
    end
    chk({tag, "_valid_seen"}, {63'b0, o_crc_valid}, 64'd1);
  endtask

  task automatic run_frame(input string tag, input byte unsigned data[$], input int pe,
                           input bit rdy, output logic [31:0] crc_seen);
    int cyc, np;
    bit lp;
    push_every = pe;
    cyc_ctr = 0;
    if (pe == 0) foreach (data[i]) fq.push_back(data[i]);
    else src = data;
    i_crc_ready = rdy;
    i_len = 16'(data.size());
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    chk({tag, "_start_pop"}, {63'b0, popped}, 64'd0);
    wait_valid(tag, cyc, np, lp);
    chk({tag, "_crc"}, {32'h0, o_crc}, {32'h0, ref_crc(data)});
    chk({tag, "_pops"}, 64'(np), 64'(data.size()));
    if (data.size() > 0) chk({tag, "_last_pop_latency"}, {63'b0, lp}, 64'd1);
    if (pe == 0) chk({tag, "_cycles"}, 64'(cyc), 64'(data.size()));
    crc_seen = o_crc;
    if (rdy) begin
      cycle();
      chk({tag, "_idle_valid"}, {63'b0, o_crc_valid}, 64'd0);
      chk({tag, "_idle_busy"}, {63'b0, o_busy}, 64'd0);
      chk({tag, "_crc_hold_idle"}, {32'h0, o_crc}, {32'h0, crc_seen});
    end
    push_every = 0;
    src.delete();
  endtask

  initial begin
    byte unsigned q[$];
    byte unsigned rest[$];
    logic [31:0]  got;
    logic [31:0]  held;
    string        s;
    int           n;

    #2 rstn = 1'b0;
    #1;
    chk("rst_pop", {63'b0, o_fifo_dpop}, 64'd0);
    chk("rst_busy", {63'b0, o_busy}, 64'd0);
    chk("rst_valid", {63'b0, o_crc_valid}, 64'd0);
    chk("rst_crc", {32'h0, o_crc}, 64'd0);
    @(negedge clk);
    cycle();
    rstn = 1'b1;
    cycle();

    s = "123456789";
    q.delete();
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    run_frame("check9", q, 0, 1'b1, got);
    chk("check9_const", {32'h0, got}, {32'h0, 32'hCBF43926});

    q.delete(); q.push_back(8'h00);
    run_frame("zero1", q, 0, 1'b1, got);
    chk("zero1_const", {32'h0, got}, {32'h0, 32'hD202EF8D});

    // Empty frame with a stray word in the FIFO: nothing may be popped.
    fq.push_back(8'hA5);
    q.delete();
    run_frame("empty", q, 0, 1'b1, got);
    chk("empty_const", {32'h0, got}, 64'd0);
    chk("empty_fifo_untouched", 64'(fq.size()), 64'd1);
    fq.delete();

    q.delete();
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    run_frame("trickle", q, 3, 1'b1, got);
    chk("trickle_const", {32'h0, got}, {32'h0, 32'hCBF43926});

    // Backpressure on the result, with a start request that must be ignored.
    q.delete();
    for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
    run_frame("hold", q, 0, 1'b0, held);
    fq.push_back(8'h3C);
    for (int k = 0; k < 10; k++) begin
      i_start = (k == 3);
      i_len = 16'd1;
      cycle();
      chk("hold_valid", {63'b0, o_crc_valid}, 64'd1);
      chk("hold_crc", {32'h0, o_crc}, {32'h0, held});
      chk("hold_nopop", {63'b0, popped}, 64'd0);
    end
    i_crc_ready = 1'b1;
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    chk("release_valid", {63'b0, o_crc_valid}, 64'd0);
    chk("release_busy", {63'b0, o_busy}, 64'd0);
    cycle();
    chk("start_on_exit_ignored", {63'b0, o_busy}, 64'd0);
    fq.delete();

    // Abort after four pops, then finish the remaining bytes as a new frame.
    for (int i = 0; i < s.len(); i++) fq.push_back(s[i]);
    i_len = 16'd9;
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    n = 0;
    for (int k = 0; k < 50 && n < 4; k++) begin
      cycle();
      if (popped) n++;
    end
    chk("clr_pops_before", 64'(n), 64'd4);
    i_clr = 1'b1;
    cycle();
    i_clr = 1'b0;
    chk("clr_nopop", {63'b0, popped}, 64'd0);
    chk("clr_busy", {63'b0, o_busy}, 64'd0);
    chk("clr_valid", {63'b0, o_crc_valid}, 64'd0);
    chk("clr_fifo_left", 64'(fq.size()), 64'd5);
    rest = fq;
    fq.delete();
    run_frame("after_clr", rest, 0, 1'b1, got);

    // Asynchronous reset in the middle of a frame.
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    foreach (q[i]) fq.push_back(q[i]);
    i_len = 16'd8;
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    cycle(); cycle(); cycle();
    rstn = 1'b0;
    #1;
    chk("midrst_pop", {63'b0, o_fifo_dpop}, 64'd0);
    chk("midrst_busy", {63'b0, o_busy}, 64'd0);
    chk("midrst_valid", {63'b0, o_crc_valid}, 64'd0);
    chk("midrst_crc", {32'h0, o_crc}, 64'd0);
    cycle();
    rstn = 1'b1;
    fq.delete();
    q.delete();
    n = $urandom_range(1, 16);
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    run_frame("post_rst", q, 0, 1'b1, got);

    for (int f = 0; f < 6; f++) begin
      q.delete();
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      run_frame("rand", q, $urandom_range(0, 3), 1'b1, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crc_fifo_drain.md
Name: crc_fifo_drain

Overview:
- Consumer stage directly downstream of the parametric FIFO.
- Pops data words from the FIFO destination interface and folds them into a running CRC for a frame of programmed length.
- Presents the final CRC on a valid/ready result port.
- Sits between the FIFO and the CRC result register/checker of the CRC engine.

Parameters:
- DW, 8, width of FIFO read data word (bits folded per pop).
- CRC_W, 32, CRC width.
- POLY, 32'h04C11DB7, generator polynomial, normal form, CRC_W bits.
- INIT, 32'hFFFFFFFF, CRC register seed at frame start.
- XOROUT, 32'hFFFFFFFF, value XORed into the CRC register before output.
- REFIN, 1, 1 = process each data word LSB first.
- REFOUT, 1, 1 = bit-reverse the CRC register before XOROUT.
- LEN_W, 16, width of frame length field (words).

Ports:
- i_par_fifo_clk  in  1  clock
- i_par_fifo_reset_b  in  1  asynchronous active-low reset
- i_clr  in  1  synchronous abort; returns to IDLE and discards the partial CRC
- i_start  in  1  frame start pulse; sampled only in IDLE
- i_len  in  LEN_W  frame length in words; sampled with i_start
- i_fifo_dempty  in  1  FIFO empty flag
- i_fifo_drdata  in  DW  FIFO head data (combinational from FIFO)
- o_fifo_dpop  out  1  FIFO pop command
- o_busy  out  1  high in RUN or DONE
- o_crc  out  CRC_W  final CRC; stable while o_crc_valid
- o_crc_valid  out  1  result valid
- i_crc_ready  in  1  result accepted

Behaviour:
- Reset: i_par_fifo_reset_b is asynchronous, active-low; clock is i_par_fifo_clk. Reset puts the FSM in IDLE. Reset values: o_fifo_dpop=0, o_busy=0, o_crc_valid=0, o_crc=0. Internal crc_reg=INIT, remaining count=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE + i_start + i_len!=0: load remaining=i_len and crc_reg=INIT, go to RUN.
  - IDLE + i_start + i_len==0: load crc_reg=INIT, go to DONE. The result is the empty-frame CRC, INIT processed through REFOUT and XOROUT.
  - RUN: o_fifo_dpop = !i_fifo_dempty, combinational, at most one pop per cycle. On each pop:
    - crc_reg <= crc_step(crc_reg, i_fifo_drdata).
    - remaining <= remaining-1.
    - If the pop has remaining==1, go to DONE.
    - If the FIFO is empty, stall in RUN with no pop and no CRC update.
  - DONE: o_crc_valid=1. o_crc is a registered value, computed as (REFOUT ? reverse(crc_reg) : crc_reg) ^ XOROUT and loaded on entry to DONE. On i_crc_ready, go to IDLE and clear o_crc_valid next cycle. o_crc holds its last value in IDLE.
- Pop rules:
  - o_fifo_dpop is never asserted outside RUN and never when i_fifo_dempty=1.
  - The data word is consumed in the same cycle the pop is asserted.
- Latency: o_crc_valid rises the cycle after the final pop. Back-to-back pops give a throughput of 1 word/clock.
- i_start in RUN or DONE is ignored; there is no queuing.
- The cycle of a DONE→IDLE transition is not IDLE, so i_start on that cycle is ignored.
- i_clr has priority over every other event in all states: next state IDLE, o_crc_valid=0, no pop in that cycle (o_fifo_dpop gated by !i_clr), crc_reg=INIT. The FIFO is not cleared by this block.
- Reset asserted mid-frame: immediate return to reset values. Words already popped are lost.
- crc_step:
  - Bit-serial over DW bits, unrolled combinationally.
  - Bit order is MSB first, or LSB first when REFIN=1.
  - Per bit: fb = crc[CRC_W-1] ^ d; crc = (crc<<1) ^ (fb ? POLY : 0).
  - All arithmetic is CRC_W bits wide and truncates.
- remaining is LEN_W bits and never underflows; the FSM exits RUN when it reaches 0.

Decomposition:
- Shared package/include crc_defs: FSM state encodings, the standard CRC-32 constants (POLY, INIT, XOROUT), and a bit-reverse function.
- Sub-module crc_step: purely combinational next-CRC for one DW word, parameterised by DW, CRC_W, POLY, REFIN. It is reused by other CRC stages.
- crc_fifo_drain holds the FSM, length counter, result register and handshake.

Test Plan:
- Load FIFO with ASCII "123456789" (9 bytes); i_start, i_len=9; i_crc_ready=1 → 9 consecutive pops; o_crc=32'hCBF43926 with o_crc_valid one cycle after the 9th pop.
- Single byte 8'h00, i_len=1 → o_crc=32'hD202EF8D. i_len=0 → no pops, o_crc=32'h00000000, valid on the cycle after start.
- "123456789" pushed one byte every 3 cycles → pops only when non-empty; no pop while empty; final o_crc=32'hCBF43926.
- Hold i_crc_ready=0 for 10 cycles after valid → o_crc_valid and o_crc stable. A second i_start during this window is ignored. ready=1 → IDLE next cycle.
- i_clr after 4 of 9 pops → no pop that cycle, IDLE, o_busy=0. Then restart with the remaining 5 bytes, i_len=5 → CRC of bytes "56789" only.
- Assert reset during RUN → all outputs at reset values the same cycle; a new frame after reset gives the correct CRC.
